// File: rtl/bka26_operand_stage.sv
// Registered operand stage feeding an external 26-bit Brent-Kung adder, with a
// 2-entry result FIFO that captures the adder sum one cycle after issue.
module bka26_operand_stage #(
  parameter int W     = 26,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic [W-1:0]     add_x,
  output logic [W-1:0]     add_y,
  input  logic [W:0]       add_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_carry,
  output logic [CNT_W-1:0] result_cnt,
  output logic             busy
);

  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     add_x_q, add_y_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] result_cnt_q, result_cnt_d;
  logic [W:0]       fifo_sum_q [2];
  logic [TAG_W-1:0] fifo_tag_q [2];

  logic fifo_has_room;
  logic accept;
  logic s1_adv;
  logic pop;

  // Handshake decisions use only registered state, so out_ready never reaches in_ready.
  always_comb begin
    fifo_has_room = (count_q != 2'd2);
    in_ready      = !s1_valid_q || fifo_has_room;
    accept        = in_valid && in_ready;
    s1_adv        = s1_valid_q && fifo_has_room;
    out_valid     = (count_q != 2'd0);
    pop           = out_valid && out_ready;
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q ^ s1_adv;
    rd_ptr_d     = rd_ptr_q ^ pop;
    result_cnt_d = result_cnt_q + {{(CNT_W-1){1'b0}}, pop};
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    // A push and a pop in the same cycle leave the occupancy unchanged.
    case ({s1_adv, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Stage 1: operand registers driving the adder inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      add_x_q    <= '0;
      add_y_q    <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        add_x_q  <= in_x;
        add_y_q  <= in_y;
        s1_tag_q <= in_tag;
      end
    end
  end

  // Stage 2: result FIFO capturing the adder sum
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_sum_q[0] <= '0;
      fifo_sum_q[1] <= '0;
      fifo_tag_q[0] <= '0;
      fifo_tag_q[1] <= '0;
    end else if (s1_adv) begin
      fifo_sum_q[wr_ptr_q] <= add_s;
      fifo_tag_q[wr_ptr_q] <= s1_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      result_cnt_q <= '0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      result_cnt_q <= result_cnt_d;
    end
  end

  always_comb begin
    add_x      = add_x_q;
    add_y      = add_y_q;
    out_sum    = fifo_sum_q[rd_ptr_q];
    out_tag    = fifo_tag_q[rd_ptr_q];
    out_carry  = out_sum[W];
    result_cnt = result_cnt_q;
    busy       = s1_valid_q || (count_q != 2'd0);
  end

endmodule

// File: tb/tb_bka26_operand_stage.sv
// Scoreboard bench for bka26_operand_stage: directed test-plan cases followed by
// randomized traffic with random consumer backpressure.
module tb_bka26_operand_stage;
  localparam int W     = 26;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_y;
  logic [TAG_W-1:0] in_tag;
  logic [W-1:0]     add_x, add_y;
  logic [W:0]       add_s;
  logic             out_valid;
  logic             out_ready;
  logic [W:0]       out_sum;
  logic [TAG_W-1:0] out_tag;
  logic             out_carry;
  logic [CNT_W-1:0] result_cnt;
  logic             busy;

  // Narrow-counter build running in lockstep on the same stimulus.
  logic             in_ready4, out_valid4, out_carry4, busy4;
  logic [W-1:0]     add_x4, add_y4;
  logic [W:0]       add_s4, out_sum4;
  logic [TAG_W-1:0] out_tag4;
  logic [3:0]       result_cnt4;

  // Parent-side adder model.
  assign add_s  = {1'b0, add_x} + {1'b0, add_y};
  assign add_s4 = {1'b0, add_x4} + {1'b0, add_y4};

  bka26_operand_stage #(.W(W), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .add_x(add_x), .add_y(add_y), .add_s(add_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_tag(out_tag), .out_carry(out_carry), .result_cnt(result_cnt), .busy(busy)
  );

  bka26_operand_stage #(.W(W), .TAG_W(TAG_W), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .add_x(add_x4), .add_y(add_y4), .add_s(add_s4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_sum(out_sum4),
    .out_tag(out_tag4), .out_carry(out_carry4), .result_cnt(result_cnt4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W:0]       sum;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         pop_cyc[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         popped = 0;
  int         last_lat = 0;
  logic [W:0] last_sum = '0;
  logic       last_carry = 1'b0;
  logic [TAG_W-1:0] last_tag = '0;
  exp_t       h;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: the scoreboard occupancy is the number of pairs accepted and not yet popped.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      popped = 0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < 3));
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      check("result_cnt", 64'(result_cnt), 64'(popped % 65536));
      check("result_cnt_w4", 64'(result_cnt4), 64'(popped % 16));
      check("out_valid_w4", 64'(out_valid4), 64'(out_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_out: got sum %0h tag %0h, expected no output", out_sum, out_tag);
        end else begin
          h = exp_q[0];
          check("out_sum", 64'(out_sum), 64'(h.sum));
          check("out_tag", 64'(out_tag), 64'(h.tag));
          check("out_carry", 64'(out_carry), 64'(h.sum[W]));
          check("latency_min", 64'(cyc - h.cyc >= 2), 64'(1));
          if (out_ready) begin
            void'(exp_q.pop_front());
            popped++;
            last_lat   = cyc - h.cyc;
            last_sum   = out_sum;
            last_carry = out_carry;
            last_tag   = out_tag;
            pop_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  // Offers one pair and holds it until accepted; the expectation is queued at acceptance.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [TAG_W-1:0] t, input int budget, output int stalls);
    exp_t e;
    stalls   = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_tag   = t;
    forever begin
      @(negedge clk);
      #1;
      if (in_ready && !rst) begin
        e.sum = (W+1)'(x) + (W+1)'(y);
        e.tag = t;
        e.cyc = cyc;
        exp_q.push_back(e);
        break;
      end
      stalls++;
      if (stalls > budget) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: got no acceptance after %0d cycles, expected acceptance", stalls);
        in_valid = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, "_drained"}, 64'(exp_q.size()), 64'(0));
    check({nm, "_idle"}, 64'(busy), 64'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return {W{1'b1}};
      default: return W'($urandom);
    endcase
  endfunction

  int   st, tot;
  logic done;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    done      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_sum", 64'(out_sum), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
    check("rst_out_carry", 64'(out_carry), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_result_cnt", 64'(result_cnt), 64'(0));
    check("rst_add_x", 64'(add_x), 64'(0));
    @(posedge clk);
    #1;

    // Single pair
    out_ready = 1'b1;
    send(26'h0000005, 26'h0000003, 4'hA, 5, st);
    in_valid = 1'b0;
    drain("single");
    check("single_sum", 64'(last_sum), 64'h8);
    check("single_tag", 64'(last_tag), 64'hA);
    check("single_carry", 64'(last_carry), 64'(0));
    check("single_latency", 64'(last_lat), 64'(2));
    check("single_cnt", 64'(result_cnt), 64'(1));

    // Max operands
    send(26'h3FFFFFF, 26'h3FFFFFF, 4'h1, 5, st);
    in_valid = 1'b0;
    drain("max");
    check("max_sum", 64'(last_sum), 64'h7FFFFFE);
    check("max_carry", 64'(last_carry), 64'(1));
    send(26'h3FFFFFF, 26'h0000001, 4'h2, 5, st);
    in_valid = 1'b0;
    drain("max1");
    check("max1_sum", 64'(last_sum), 64'h4000000);
    check("max1_carry", 64'(last_carry), 64'(1));

    // Streaming back-to-back
    pop_cyc.delete();
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      send(W'(i), W'(2 * i), TAG_W'(i), 5, st);
      tot += st;
    end
    in_valid = 1'b0;
    drain("stream");
    check("stream_stalls", 64'(tot), 64'(0));
    check("stream_pops", 64'(pop_cyc.size()), 64'(10));
    if (pop_cyc.size() == 10)
      check("stream_consecutive", 64'(pop_cyc[9] - pop_cyc[0]), 64'(9));
    check("stream_last_sum", 64'(last_sum), 64'(27));
    check("stream_cnt", 64'(result_cnt), 64'(13));

    // Four more results make 17: the 4-bit counter wraps to 1
    for (int i = 0; i < 4; i++) begin
      send(pick(), pick(), TAG_W'($urandom), 5, st);
      in_valid = 1'b0;
      drain("wrap");
    end
    check("wrap_cnt4", 64'(result_cnt4), 64'(1));
    check("wrap_cnt16", 64'(result_cnt), 64'(17));

    // Backpressure: three accepted, the fourth stalls until the first pop
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(W'(100 * i), W'(i), TAG_W'(i), 5, st);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    check("bp_head_sum", 64'(out_sum), 64'(101));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(W'(400), W'(4), 4'h4, 10, st);
    in_valid = 1'b0;
    check("bp_fourth_stalled", 64'(st > 0), 64'(1));
    drain("bp");
    check("bp_last_sum", 64'(last_sum), 64'(404));
    check("bp_cnt", 64'(result_cnt), 64'(21));

    // Reset with two results queued and s1 full
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(W'(i + 50), W'(1), 4'h7, 5, st);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_cnt", 64'(result_cnt), 64'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(26'h0000007, 26'h0000009, 4'h3, 5, st);
    in_valid = 1'b0;
    drain("post_rst");
    check("post_rst_sum", 64'(last_sum), 64'h10);
    check("post_rst_cnt", 64'(result_cnt), 64'(1));

    // Randomized traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(pick(), pick(), TAG_W'($urandom), 50, st);
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk);
              #1;
            end
          end
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
